reg_slice_skid: RTL
===================

// Module: reg_slice_skid
// PURPOSE
//  Two-entry valid/ready register slice (skid buffer) for cutting timing paths between pipeline stages.
//  Accepts one beat per cycle from an upstream producer and presents it to a downstream consumer.
//  in_ready and out_valid are both driven straight from flops, so it breaks both the forward and backward paths.
//  Sits between any two handshaked datapath stages; it is the consumer-side companion to the enable-register library.
// PARAMETERS
//  WIDTH   32   payload width in bits (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_data    in   WIDTH  upstream payload
//  in_valid   in   1      upstream beat offered
//  in_ready   out  1      slice can accept; registered
//  out_data   out  WIDTH  downstream payload; registered
//  out_valid  out  1      downstream beat offered; registered
//  out_ready  in   1      downstream accepts
//  xfer_cnt   out  16     accepted-beat count; present only with REG_SLICE_STAT_EN
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
//  - Reset values while rst_n=0: state=EMPTY, out_valid=0, out_data=0, skid=0, in_ready=1, xfer_cnt=0.
//  - Mid-operation reset: the async assert drops all held beats immediately; nothing is replayed.
//  - Handshake fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Payload order is strictly FIFO; no beat is lost or duplicated.
//  - Latency: 1 cycle from in_fire to out_valid=1 when the slice is EMPTY. Sustained throughput is 1 beat/cycle.
//  - out_data and out_valid stay stable while out_valid=1 & out_ready=0 (AXI-style).
//  - in_valid may drop without a fire. The slice ignores in_data whenever in_fire=0.
//  - State machine (2-bit):
//    EMPTY: out_valid=0, in_ready=1.
//      in_fire -> main<=in_data, go BUSY.
//    BUSY: out_valid=1, in_ready=1.
//      in_fire & out_fire -> main<=in_data, stay BUSY.
//      in_fire & !out_fire -> skid<=in_data, go FULL; in_ready drops next cycle.
//      !in_fire & out_fire -> go EMPTY.
//    FULL: out_valid=1, in_ready=0.
//      out_fire -> main<=skid, go BUSY; in_ready rises next cycle.
//      otherwise hold.
//  - Simultaneous in_valid & out_ready when FULL: only the output fires, because in_ready=0.
//  - Illegal state encoding (2'b11) -> next state EMPTY.
// CONFIGURATION
//  - Macro REG_SLICE_STAT_EN. When defined, xfer_cnt exists.
//    - Increments by 1 on every in_fire and wraps 0xFFFF -> 0x0000.
//    - Reset value 0. It is not cleared by any other signal.
//  - When undefined: the port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package reg_pkg:
//    - localparams RS_EMPTY=2'd0, RS_BUSY=2'd1, RS_FULL=2'd2.
//    - REG_SLICE_CNT_W=16.
//  - Sub-module reg_w_en_arn: a WIDTH-bit enabled register with async active-low clear.
//    - Instantiated twice, for main (out_data) and skid.
//  - The control FSM and the ready/valid flops live in reg_slice_skid itself.
// TESTING
//  - Reset: hold rst_n=0 for 3 clocks -> out_valid=0, out_data=0, in_ready=1.
//    Then release rst_n with in_valid=0 -> state stays EMPTY.
//  - Single beat: in_data=0xA5A5A5A5 with in_valid for 1 cycle, out_ready=1.
//    -> out_valid=1 with out_data=0xA5A5A5A5 the next cycle, for exactly 1 cycle.
//  - Streaming: in_data=1..100 back-to-back, in_valid=1 and out_ready=1 throughout.
//    -> out_data=1..100 on consecutive cycles, in_ready never drops.
//  - Backpressure: in_data=1,2,3 with out_ready=0.
//    -> beats 1 and 2 are accepted, then in_ready=0 and beat 3 is held upstream.
//    Then out_ready=1 -> output sequence 1,2,3 in order, no gaps after the first.
//  - Random stall: random in_valid and out_ready at 50%, 10k beats.
//    -> scoreboard matches in order, and out_data is stable whenever out_valid & !out_ready.
//  - Reset while FULL: assert rst_n=0 mid-cycle.
//    -> out_valid=0 immediately (async). After release, the first new beat appears unaffected by the old data.
//  - With REG_SLICE_STAT_EN: preload 65535 fires, then 1 more -> xfer_cnt wraps to 0.

Source files
------------

// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_pkg
//  Description : Shared state encodings and widths for the register-slice library.
//  Revision    : 1.0
// ============================================================================
package reg_pkg;

    typedef logic [1:0] rs_state_t;

    localparam rs_state_t RS_EMPTY = 2'd0;
    localparam rs_state_t RS_BUSY  = 2'd1;
    localparam rs_state_t RS_FULL  = 2'd2;

    localparam int REG_SLICE_CNT_W = 16;

endpackage : reg_pkg
`default_nettype wire

// File: rtl/reg_w_en_arn.sv
`default_nettype none
// ============================================================================
//  Module      : reg_w_en_arn
//  Description : WIDTH-bit load-enabled register with async active-low clear.
//  Revision    : 1.0
// ============================================================================
module reg_w_en_arn #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : reg_w_en_arn
`default_nettype wire

// File: rtl/reg_slice_skid.sv
`default_nettype none
// ============================================================================
//  Module      : reg_slice_skid
//  Description : Two-entry valid/ready skid slice; in_ready and out_valid are
//                flop outputs. Optional xfer_cnt port with REG_SLICE_STAT_EN.
//  Revision    : 1.0
// ============================================================================
module reg_slice_skid
    import reg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef REG_SLICE_STAT_EN
    ,
    output logic [REG_SLICE_CNT_W-1:0] xfer_cnt
`endif
);

    rs_state_t        state_q;
    rs_state_t        state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] skid_q;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_main_en;
    logic [WIDTH-1:0] w_main_d;
    logic             w_skid_en;

    assign w_in_fire  = in_valid & in_ready_q;
    assign w_out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d   = state_q;
        w_main_en = 1'b0;
        w_main_d  = in_data;
        w_skid_en = 1'b0;
        case (state_q)
            RS_EMPTY: begin
                if (w_in_fire) begin
                    w_main_en = 1'b1;
                    state_d   = RS_BUSY;
                end
            end
            RS_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_en = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_en = 1'b1;
                    state_d   = RS_FULL;
                end else if (w_out_fire) begin
                    state_d   = RS_EMPTY;
                end
            end
            RS_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (w_out_fire) begin
                    w_main_en = 1'b1;
                    w_main_d  = skid_q;
                    state_d   = RS_BUSY;
                end
            end
            default: begin
                state_d = RS_EMPTY;
            end
        endcase
    end

    // Handshake flags are precomputed from the next state so both ports stay flop-driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RS_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != RS_FULL);
            out_valid_q <= (state_d != RS_EMPTY);
        end
    end

    reg_w_en_arn #(
        .WIDTH (WIDTH)
    ) u_main_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (w_main_en),
        .d_i   (w_main_d),
        .q_o   (out_data)
    );

    reg_w_en_arn #(
        .WIDTH (WIDTH)
    ) u_skid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (w_skid_en),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`ifdef REG_SLICE_STAT_EN
    logic [REG_SLICE_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (w_in_fire) begin
            cnt_q <= cnt_q + REG_SLICE_CNT_W'(1);
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule : reg_slice_skid
`default_nettype wire
